// File: rtl/freq_meter_pkg.sv
// Shared definitions for the auto-ranging frequency/period meter:
// FSM state encoding, measurement-mode constants and elaboration-time helpers.
package freq_meter_pkg;

  // state   | meaning
  // IDLE    | waiting for start, ready high
  // WAIT1   | waiting for the opening rising edge of si
  // COUNT   | counting system cycles until the closing rising edge
  // DIV     | sequential division producing the scaled result Q
  // B2B     | double-dabble conversion of Q to BCD
  // NORM    | locating the most significant nonzero digit
  // DONE    | registering outputs and pulsing done_tick
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT1,
    S_COUNT,
    S_DIV,
    S_B2B,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic MODE_FREQ   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  // 10^n as a 64-bit constant; only used at elaboration time.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Number of BCD digits needed for a w-bit binary value: ceil(w * log10(2)).
  // The slightly rounded-up constant can only ever add a spare digit.
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, W cycles per division.
// Operands are captured on start; done_tick pulses once quo is final.
module seq_divider #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dvnd,
  input  logic [W-1:0] dvsr,
  output logic         done_tick,
  output logic [W-1:0] quo
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvsr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W:0]    w_diff;

  // Trial subtraction of the divisor from the shifted partial remainder;
  // the top bit set means the trial went negative and the remainder is kept.
  assign w_diff = {r_rem, r_quo[W-1]} - {1'b0, r_dvsr};

  // Load operands on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_quo  <= dvnd;
        r_dvsr <= dvsr;
        r_cnt  <= CW'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_diff[W]) begin
          r_rem <= {r_rem[W-2:0], r_quo[W-1]};
        end else begin
          r_rem <= w_diff[W-1:0];
        end
        r_quo <= {r_quo[W-2:0], ~w_diff[W]};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done_tick = r_done;
  assign quo       = r_quo;

endmodule

// File: rtl/auto_range_freq_meter.sv
// Auto-ranging frequency / period meter. Measures one full period of si in
// system-clock cycles, scales it to a DIGITS-digit BCD value with a decimal
// point position, and flags over-range and timeout conditions.
module auto_range_freq_meter
  import freq_meter_pkg::*;
#(
  parameter longint unsigned CLK_HZ      = 100_000_000,
  parameter int              DIGITS      = 4,
  parameter longint unsigned TIMEOUT_CYC = 200_000_000,
  parameter int              DIV_W       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  mode,
  input  logic                  si,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            dp_pos,
  output logic                  over_range,
  output logic                  timeout
);

  localparam int NB = bcd_digits(DIV_W);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(DIV_W + 1);
  localparam int MW = $clog2(NB);

  localparam logic [CW-1:0]    C_TO       = CW'(TIMEOUT_CYC);
  localparam logic [DIV_W-1:0] C_FREQ_NUM = DIV_W'(CLK_HZ * pow10(DIGITS - 1));
  localparam logic [DIV_W-1:0] C_PER_MUL  = DIV_W'(pow10(DIGITS + 5));
  localparam logic [DIV_W-1:0] C_CLK      = DIV_W'(CLK_HZ);
  localparam logic [SW-1:0]    C_STEPS    = SW'(DIV_W);
  localparam logic [MW-1:0]    C_IDX_TOP  = MW'(NB - 1);
  localparam logic [MW-1:0]    C_IDX_MIN  = MW'(DIGITS - 1);

  // input conditioning
  logic r_si_meta;
  logic r_si_sync;
  logic r_si_prev;
  logic w_rise;

  // control and datapath
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_p;
  logic            r_mode;
  logic            r_to;
  logic            r_div_go;
  logic [DIV_W-1:0] r_bin;
  logic [4*NB-1:0] r_bcd;
  logic [SW-1:0]   r_step;
  logic [MW-1:0]   r_idx;

  // registered outputs
  logic                r_ready;
  logic                r_done_tick;
  logic [4*DIGITS-1:0] r_bcd_out;
  logic [2:0]          r_dp;
  logic                r_over;
  logic                r_timeout;

  logic [DIV_W-1:0]    w_dvnd;
  logic [DIV_W-1:0]    w_dvsr;
  logic [DIV_W-1:0]    w_quo;
  logic                w_div_done;
  logic [4*NB-1:0]     w_adj;
  logic [3:0]          w_top_digit;
  logic                w_over;

  // Two-flop synchronizer on si plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_si_meta <= 1'b0;
      r_si_sync <= 1'b0;
      r_si_prev <= 1'b0;
    end else begin
      r_si_meta <= si;
      r_si_sync <= r_si_meta;
      r_si_prev <= r_si_sync;
    end
  end

  assign w_rise = r_si_sync & ~r_si_prev;

  // Frequency: CLK_HZ*10^(D-1) / P.  Period: P*10^(D+5) / CLK_HZ.
  // Both give the displayed value scaled by 10^(D-1).
  assign w_dvnd = (r_mode == MODE_PERIOD) ? DIV_W'(r_p) * C_PER_MUL : C_FREQ_NUM;
  assign w_dvsr = (r_mode == MODE_PERIOD) ? C_CLK : DIV_W'(r_p);

  seq_divider #(
    .W (DIV_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (r_div_go),
    .dvnd      (w_dvnd),
    .dvsr      (w_dvsr),
    .done_tick (w_div_done),
    .quo       (w_quo)
  );

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NB; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // During NORM the BCD register is shifted up so the digit under test is always on top.
  assign w_top_digit = r_bcd[4*NB-1 -: 4];
  assign w_over      = (int'(r_idx) > 2*DIGITS - 2);

  // Measurement sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_mode      <= MODE_FREQ;
      r_to        <= 1'b0;
      r_div_go    <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_step      <= '0;
      r_idx       <= '0;
      r_ready     <= 1'b1;
      r_done_tick <= 1'b0;
      r_bcd_out   <= '0;
      r_dp        <= '0;
      r_over      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done_tick <= 1'b0;
      r_div_go    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_cnt   <= '0;
            r_to    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          // timeout is checked first so it wins over a coincident rise
          if (r_cnt == C_TO) begin
            r_to    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_rise) begin
            r_cnt   <= '0;
            r_state <= S_COUNT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_COUNT: begin
          if (r_cnt == C_TO) begin
            r_to    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_rise) begin
            // counter holds P-1 on the cycle the closing edge is seen
            r_p      <= r_cnt + CW'(1);
            r_div_go <= 1'b1;
            r_state  <= S_DIV;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_bin   <= w_quo;
            r_bcd   <= '0;
            r_step  <= C_STEPS;
            r_state <= S_B2B;
          end
        end
        S_B2B: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_step <= r_step - SW'(1);
          if (r_step == SW'(1)) begin
            r_idx   <= C_IDX_TOP;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if ((w_top_digit != 4'd0) || (r_idx == C_IDX_MIN)) begin
            r_state <= S_DONE;
          end else begin
            r_bcd <= r_bcd << 4;
            r_idx <= r_idx - MW'(1);
          end
        end
        S_DONE: begin
          r_done_tick <= 1'b1;
          if (r_to) begin
            r_bcd_out <= '0;
            r_dp      <= '0;
            r_over    <= 1'b0;
            r_timeout <= 1'b1;
          end else if (w_over) begin
            r_bcd_out <= {DIGITS{4'h9}};
            r_dp      <= '0;
            r_over    <= 1'b1;
            r_timeout <= 1'b0;
          end else begin
            r_bcd_out <= r_bcd[4*NB-1 -: 4*DIGITS];
            r_dp      <= 3'(2*DIGITS - 2 - int'(r_idx));
            r_over    <= 1'b0;
            r_timeout <= 1'b0;
          end
          if (cont) begin
            r_cnt   <= '0;
            r_to    <= 1'b0;
            r_state <= S_WAIT1;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign done_tick  = r_done_tick;
  assign bcd        = r_bcd_out;
  assign dp_pos     = r_dp;
  assign over_range = r_over;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_auto_range_freq_meter.sv
// Directed bench for auto_range_freq_meter. Clock rate is scaled to
// CLK_HZ=100_000 so every period stays short; expected results are the
// hand-computed displays for each period. A second instance with a short
// timeout covers the no-signal case.
module tb_auto_range_freq_meter;

  typedef struct packed {
    logic [15:0] bcd;
    logic [2:0]  dp;
    logic        over;
    logic        to;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cont;
  logic        mode;
  logic        si;
  logic        ready;
  logic        done_tick;
  logic [15:0] bcd;
  logic [2:0]  dp_pos;
  logic        over_range;
  logic        timeout;

  logic        start2;
  logic        cont2;
  logic        mode2;
  logic        si_lo;
  logic        ready2;
  logic        done2;
  logic [15:0] bcd2;
  logic [2:0]  dp2;
  logic        over2;
  logic        to2;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done = 0;
  int   per = 0;
  exp_t sb[$];

  auto_range_freq_meter #(
    .CLK_HZ      (100_000),
    .DIGITS      (4),
    .TIMEOUT_CYC (50_000),
    .DIV_W       (48)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cont       (cont),
    .mode       (mode),
    .si         (si),
    .ready      (ready),
    .done_tick  (done_tick),
    .bcd        (bcd),
    .dp_pos     (dp_pos),
    .over_range (over_range),
    .timeout    (timeout)
  );

  auto_range_freq_meter #(
    .CLK_HZ      (100_000),
    .DIGITS      (4),
    .TIMEOUT_CYC (1000),
    .DIV_W       (48)
  ) dut_to (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .cont       (cont2),
    .mode       (mode2),
    .si         (si_lo),
    .ready      (ready2),
    .done_tick  (done2),
    .bcd        (bcd2),
    .dp_pos     (dp2),
    .over_range (over2),
    .timeout    (to2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Square wave of period 'per' cycles; a change of 'per' restarts the phase with a high level.
  initial begin : gen
    int ph;
    int last;
    ph = 0;
    last = 0;
    si = 1'b0;
    forever begin
      @(negedge clk);
      if (per != last) begin
        last = per;
        ph = 0;
      end else if (per != 0) begin
        ph = (ph >= per - 1) ? 0 : ph + 1;
      end
      si = (per != 0) && (ph < per / 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for done_tick, pop the scoreboard and compare, then confirm the pulse is one cycle.
  task automatic wait_done(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (done_tick !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(done_tick), 32'd1);
    if (done_tick === 1'b1) begin
      last_done = cyc;
      chk({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
      chk({tag, "_dp"}, 32'(dp_pos), 32'(e.dp));
      chk({tag, "_over"}, 32'(over_range), 32'(e.over));
      chk({tag, "_timeout"}, 32'(timeout), 32'(e.to));
      @(negedge clk);
      chk({tag, "_pulse_width"}, 32'(done_tick), 32'd0);
    end
  endtask

  // Single-shot measurement; mode is flipped right after start to show it is latched.
  task automatic measure(input int p, input logic md, input logic [15:0] eb,
                         input logic [2:0] ed, input logic eo, input string tag);
    exp_t e;
    per = p;
    repeat (5) @(negedge clk);
    mode = md;
    start = 1'b1;
    e.bcd = eb;
    e.dp = ed;
    e.over = eo;
    e.to = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mode = ~md;
    wait_done(tag, 2 * p + 400);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    mode = md;
  endtask

  initial begin : main
    exp_t e;
    int   n;
    int   t1;
    int   seen;
    reset = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    mode = 1'b0;
    start2 = 1'b0;
    cont2 = 1'b0;
    mode2 = 1'b0;
    si_lo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_dp", 32'(dp_pos), 32'd0);
    chk("rst_over", 32'(over_range), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // frequency mode
    measure(17000, 1'b0, 16'h5882, 3'd3, 1'b0, "f17000");
    measure(1700,  1'b0, 16'h5882, 3'd2, 1'b0, "f1700");
    measure(300,   1'b0, 16'h3333, 3'd1, 1'b0, "f300");
    measure(100,   1'b0, 16'h1000, 3'd0, 1'b0, "f100");
    measure(10,    1'b0, 16'h9999, 3'd0, 1'b1, "f10_over");
    measure(2,     1'b0, 16'h9999, 3'd0, 1'b1, "f2_over");
    // period mode
    measure(300,   1'b1, 16'h3000, 3'd0, 1'b0, "p300");
    measure(11,    1'b1, 16'h1100, 3'd1, 1'b0, "p11");
    measure(3,     1'b1, 16'h3000, 3'd2, 1'b0, "p3");
    measure(2,     1'b1, 16'h2000, 3'd2, 1'b0, "p2");

    // timeout with si held low
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("to_done_seen", 32'(done2), 32'd1);
    chk("to_latency_max", 32'(n <= 1003), 32'd1);
    chk("to_latency_min", 32'(n >= 1000), 32'd1);
    chk("to_flag", 32'(to2), 32'd1);
    chk("to_bcd", 32'(bcd2), 32'd0);
    chk("to_dp", 32'(dp2), 32'd0);
    chk("to_over", 32'(over2), 32'd0);
    @(negedge clk);
    chk("to_ready", 32'(ready2), 32'd1);

    // continuous mode
    cont = 1'b1;
    per = 300;
    repeat (5) @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    e.bcd = 16'h3333;
    e.dp = 3'd1;
    e.over = 1'b0;
    e.to = 1'b0;
    repeat (3) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done("cont1", 1000);
    t1 = last_done;
    wait_done("cont2", 1000);
    chk("cont_gap", 32'(last_done - t1), 32'd600);
    chk("cont_busy", 32'(ready), 32'd0);
    cont = 1'b0;
    wait_done("cont3", 1000);
    chk("cont_stop_ready", 32'(ready), 32'd1);

    // reset in the middle of COUNT
    per = 1000;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1500) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done", 32'(done_tick), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    chk("mid_rst_dp", 32'(dp_pos), 32'd0);
    chk("mid_rst_over", 32'(over_range), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    seen = 0;
    repeat (2500) begin
      @(negedge clk);
      if (done_tick === 1'b1) seen++;
    end
    chk("mid_rst_idle", 32'(seen), 32'd0);
    measure(1000, 1'b0, 16'h1000, 3'd1, 1'b0, "after_rst_f1000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
